// File: rtl/literal_stream_decoder_pkg.sv
// literal_pkg: shared constants, FSM state type and a count-width helper
// for the streaming BITS literal decoder.
package literal_pkg;

  localparam int GROUP_W  = 5;
  localparam int NIBBLE_W = 4;
  localparam int CONT_BIT = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Wide enough to hold MAX_GROUPS+1 (saturated overflow marker).
  function automatic int cnt_w(input int max_groups);
    return $clog2(max_groups + 2);
  endfunction

endpackage

// File: rtl/literal_stream_decoder_if.sv
// Stream bundle for literal_stream_decoder.
// Input side: in_valid/in_ready/in_group (5-bit group).
// Output side: out_valid/out_ready/out_value/out_bit_len/out_overflow.
interface literal_stream_decoder_if #(
  parameter int VALUE_W = 64,
  parameter int BLEN_W  = 16
);
  import literal_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [GROUP_W-1:0]    in_group;
  logic                  out_valid;
  logic                  out_ready;
  logic [VALUE_W-1:0]    out_value;
  logic [BLEN_W-1:0]     out_bit_len;
  logic                  out_overflow;

  // master: group producer / literal consumer
  modport master (
    output in_valid, in_group, out_ready,
    input  in_ready, out_valid, out_value,
    input  out_bit_len, out_overflow
  );

  // slave: the decoder
  modport slave (
    input  in_valid, in_group, out_ready,
    output in_ready, out_valid, out_value,
    output out_bit_len, out_overflow
  );

endinterface

// File: rtl/literal_stream_decoder.sv
// Streaming BITS literal decoder: accumulates 5-bit groups (cont + nibble)
// into a VALUE_W literal with saturating bit length.
// Ports: clk, reset (async, active-high), bus (literal_stream_decoder_if.slave).
// Optional LITERAL_OVERFLOW_CHECK_EN: freeze value after MAX_GROUPS
// nibbles and flag out_overflow; otherwise value wraps and flag is 0.
module literal_stream_decoder
  import literal_pkg::*;
#(
  parameter int MAX_GROUPS = 16,
  parameter int BLEN_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  literal_stream_decoder_if.slave  bus
);

  localparam int VALUE_W = NIBBLE_W * MAX_GROUPS;
  localparam logic [BLEN_W-1:0] BLEN_MAX = '1;
  localparam logic [BLEN_W:0] GRP_BITS = (BLEN_W+1)'(GROUP_W);
  // Length after the first group, saturated for tiny BLEN_W.
  localparam logic [BLEN_W-1:0] BLEN_FIRST =
    (GRP_BITS > {1'b0, BLEN_MAX}) ? BLEN_MAX : GRP_BITS[BLEN_W-1:0];

  state_t r_state, w_state_n;
  logic [VALUE_W-1:0] r_acc, w_acc_n;
  logic [BLEN_W-1:0]  r_blen, w_blen_n;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_cont;
  logic [NIBBLE_W-1:0] w_nib;
  logic [VALUE_W-1:0]  w_shift;
  logic [BLEN_W:0]     w_blen_sum;
  logic [BLEN_W-1:0]   w_blen_add;

`ifdef LITERAL_OVERFLOW_CHECK_EN
  localparam int CW = cnt_w(MAX_GROUPS);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_GROUPS);
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_ovf, w_ovf_n;
`endif

  assign w_cont = bus.in_group[CONT_BIT];
  assign w_nib  = bus.in_group[NIBBLE_W-1:0];

  assign bus.in_ready  = (r_state == ACCUM) || bus.out_ready;
  assign bus.out_valid = (r_state == HOLD);
  assign w_in_fire     = bus.in_valid && bus.in_ready;
  assign w_out_fire    = (r_state == HOLD) && bus.out_ready;

  // Low VALUE_W bits of {acc, nibble}: oldest nibble falls off the top.
  assign w_shift    = VALUE_W'({r_acc, w_nib});
  assign w_blen_sum = {1'b0, r_blen} + GRP_BITS;
  assign w_blen_add = w_blen_sum[BLEN_W] ? BLEN_MAX
                                         : w_blen_sum[BLEN_W-1:0];

  assign bus.out_value   = r_acc;
  assign bus.out_bit_len = r_blen;
`ifdef LITERAL_OVERFLOW_CHECK_EN
  assign bus.out_overflow = r_ovf;
`else
  assign bus.out_overflow = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_blen_n  = r_blen;
`ifdef LITERAL_OVERFLOW_CHECK_EN
    w_cnt_n   = r_cnt;
    w_ovf_n   = r_ovf;
`endif
    unique case (r_state)
      ACCUM: begin
        if (w_in_fire) begin
          w_blen_n = w_blen_add;
`ifdef LITERAL_OVERFLOW_CHECK_EN
          if (r_cnt < CNT_FULL) begin
            w_acc_n = w_shift;
            w_cnt_n = r_cnt + CW'(1);
          end else begin
            w_cnt_n = CNT_FULL + CW'(1);
            w_ovf_n = 1'b1;
          end
`else
          w_acc_n = w_shift;
`endif
          if (!w_cont) w_state_n = HOLD;
        end
      end
      HOLD: begin
        if (w_out_fire) begin
          if (w_in_fire) begin
            // Same-cycle hand-off: this group opens the next literal.
            w_acc_n  = VALUE_W'(w_nib);
            w_blen_n = BLEN_FIRST;
`ifdef LITERAL_OVERFLOW_CHECK_EN
            w_cnt_n  = CW'(1);
            w_ovf_n  = 1'b0;
`endif
            if (w_cont) w_state_n = ACCUM;
          end else begin
            w_acc_n   = '0;
            w_blen_n  = '0;
`ifdef LITERAL_OVERFLOW_CHECK_EN
            w_cnt_n   = '0;
            w_ovf_n   = 1'b0;
`endif
            w_state_n = ACCUM;
          end
        end
      end
      default: w_state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_blen  <= '0;
`ifdef LITERAL_OVERFLOW_CHECK_EN
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_blen  <= w_blen_n;
`ifdef LITERAL_OVERFLOW_CHECK_EN
      r_cnt   <= w_cnt_n;
      r_ovf   <= w_ovf_n;
`endif
    end
  end

endmodule

// File: doc/literal_stream_decoder.md
# literal_stream_decoder

Sequential, parametrised successor to the 16-nibble combinational literal decoder in the packet-decode path. It accepts BITS literal-value groups (1 continuation bit + 4 data bits) one per beat over a valid/ready stream and accumulates nibbles up to a configurable depth. It emits the assembled value, the number of bits consumed and an overflow flag on an output valid/ready handshake. It sits between the packet header parser (which strips version/type ID 4) and the operator evaluator.

## Interface
- MAX_GROUPS, 16: groups held without loss; VALUE_W = 4*MAX_GROUPS
- BLEN_W, 16: width of consumed-bit-length counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_group is valid
- in_ready  output  1  block accepts a group this cycle
- in_group  input  5  [4]=continuation (1 = more follow), [3:0]=nibble, MSB-first
- out_valid  output  1  literal complete, held until accepted
- out_ready  input  1  downstream accepts the literal
- out_value  output  VALUE_W  assembled literal, zero-extended
- out_bit_len  output  BLEN_W  bits consumed = 5 * groups accepted, saturating
- out_overflow  output  1  more than MAX_GROUPS groups seen (see Configuration)

## Operation
- States: ACCUM (collecting; group count may be 0), HOLD (out_valid=1).
- in_ready = (state==ACCUM) || out_ready. Group fires on in_valid && in_ready.
- ACCUM, group fires: acc <= {acc[VALUE_W-5:0], nibble}; count += 1; bit_len += 5 (saturates at 2^BLEN_W-1). If continuation==0, go to HOLD with these updated values.
- HOLD: out_value/out_bit_len/out_overflow stable. Output fires on out_valid && out_ready.
  - Without a simultaneous input fire: clear acc, count, bit_len and overflow, then return to ACCUM.
  - With a simultaneous input fire: the group starts a new literal. acc <= nibble; count=1; bit_len=5; overflow=0. If its continuation==0, stay in HOLD. Otherwise go to ACCUM.
- A literal of one group (continuation=0 first) is legal: value = nibble, bit_len = 5.
- No timeout and no abort. An unterminated literal stays in ACCUM indefinitely.
- Reset mid-literal discards the partial value. No output is produced for it.
- Reset values:
  - state=ACCUM, in_ready=1 (combinational), out_valid=0.
  - out_value=0, out_bit_len=0, out_overflow=0, internal count=0.

## Timing
- Terminating group accepted at edge N → out_valid=1 after edge N (latency 1 cycle).
- Throughput: one group per cycle, including back-to-back literals, while out_ready=1.
- out_valid/out_* are registered. in_ready depends combinationally on out_ready only.
- out_* must not change while out_valid && !out_ready.

## Configuration
- LITERAL_OVERFLOW_CHECK_EN defined:
  - count saturates at MAX_GROUPS+1.
  - Groups beyond MAX_GROUPS do not shift acc. Value is frozen at the first MAX_GROUPS nibbles, i.e. the most-significant portion.
  - out_overflow=1 for that literal. bit_len keeps counting.
- Not defined:
  - acc always shifts. Value is the literal mod 2^VALUE_W, i.e. the last MAX_GROUPS nibbles.
  - out_overflow tied to 0; count logic is omitted.

## Structure
- Shared package literal_pkg:
  - GROUP_W=5, NIBBLE_W=4, CONT_BIT=4 constants.
  - State enum {ACCUM, HOLD}.
  - Function for count width: $clog2(MAX_GROUPS+2).
- No sub-module. Group split is two bit slices. Datapath and FSM live in one module.

## Test plan
- Groups 10111, 11110, 00101 back-to-back, out_ready=1 → out_value=0x7E5 (2021), out_bit_len=15, out_overflow=0, out_valid one cycle after third group.
- Single group 01010 → out_value=0xA, out_bit_len=5. Then with out_ready=0 for 4 cycles: in_ready=0 and outputs stable. Release → accepted.
- Two literals streamed without gaps (00011, then 1000F→10001,00010), out_ready=1 → values 0x3 then 0x12, no idle cycle, second literal not contaminated by first.
- MAX_GROUPS=2 with macro, groups 10001,10010,00011 → out_value=0x12, out_bit_len=15, out_overflow=1. Without macro → out_value=0x23, out_overflow=0.
- Assert reset after 2 continuation groups, then send 00111 → out_value=0x7, out_bit_len=5. During reset: out_valid=0, in_ready=1.
- BLEN_W=4, MAX_GROUPS=16, 4 groups → out_bit_len saturates at 15.
